// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Bundles the request/response handshake from the MEM stage together with
//   the word-only data-memory port of the load/store unit.
//
//   Handshake: a request transfers on a rising edge where ReqValid and
//   ReqReady are both high; the requester keeps ReqValid and the request
//   fields stable until then. RspValid is a single-cycle completion pulse
//   with no back-pressure; Misaligned is meaningful only while RspValid is high.
//
//   Modports:
//     slave  - the load/store unit (serves requests, drives the memory port)
//     master - the environment (requester plus data memory)
interface load_store_unit_if;
    // request / response side
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqUnsigned;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        RspValid;
    logic [31:0] ReadData;
    logic        Misaligned;
    // data memory side
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemReadData;

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, Address, WriteData,
        input  MemReadData,
        output ReqReady, RspValid, ReadData, Misaligned,
        output MemAddress, MemWriteData, MemRead, MemWrite
    );

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqUnsigned, Address, WriteData,
        output MemReadData,
        input  ReqReady, RspValid, ReadData, Misaligned,
        input  MemAddress, MemWriteData, MemRead, MemWrite
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator-side load/store controller between the MEM stage and a
//   word-only synchronous data memory (little-endian lanes). Handles byte,
//   halfword and word accesses one at a time; sub-word stores are done as
//   read-modify-write, sub-word loads are lane-extracted and sign/zero
//   extended. Misaligned or illegal-size requests are rejected without any
//   memory access.
//
//   Parameters:
//     RD_LAT    - memory read latency in cycles (>= 1)
//   Ports:
//     Clk       - clock, rising edge
//     Reset     - synchronous, active-high reset
//     bus       - request/response + memory port bundle (slave view)
//     dbg_state - current FSM state encoding, for observation only
module load_store_unit #(
    parameter int RD_LAT = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    load_store_unit_if.slave bus,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam int            CW      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] RD_LAST = CW'(RD_LAT - 1);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] rd_cnt;

    // latched request fields (only what later states actually need)
    logic          write_q;
    logic          uns_q;
    logic [1:0]    size_q;
    logic [1:0]    lane_q;
    logic [15:0]   wdata_q;

    // registered outputs
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic          misaligned_q;
    logic          mem_read_q;
    logic          mem_write_q;
    logic [31:0]   read_data_q;
    logic [31:0]   mem_address_q;
    logic [31:0]   mem_wdata_q;

    logic          accept;
    logic          illegal_in;
    logic          word_store_in;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;
    logic [31:0]   merge_val;

    assign accept        = bus.ReqValid && (state == IDLE);
    assign word_store_in = bus.ReqWrite && (bus.ReqSize == 2'b00);
    assign illegal_in    = (bus.ReqSize == 2'b11)
                        || ((bus.ReqSize == 2'b01) && bus.Address[0])
                        || ((bus.ReqSize == 2'b00) && (bus.Address[1:0] != 2'b00));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (illegal_in) begin
                        next_state = RESP;
                    end else if (word_store_in) begin
                        next_state = WR;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            RD: begin
                if (rd_cnt == RD_LAST) begin
                    next_state = CAP;
                end
            end
            CAP:     next_state = write_q ? WR : RESP;
            WR:      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------ lane extract / merge
    always_comb begin
        byte_sel = bus.MemReadData[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? bus.MemReadData[31:16] : bus.MemReadData[15:0];
        case (size_q)
            2'b10:   load_val = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = bus.MemReadData;
        endcase
    end

    always_comb begin
        merge_val = bus.MemReadData;
        case (size_q)
            2'b10: merge_val[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (lane_q[1]) begin
                    merge_val[31:16] = wdata_q;
                end else begin
                    merge_val[15:0] = wdata_q;
                end
            end
            default: merge_val = bus.MemReadData;
        endcase
    end

    // ------------------------------------------- datapath + output registers
    // Strobes are registered from next_state so every output is a flop and
    // lines up exactly with the state it belongs to.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_cnt        <= '0;
            write_q       <= 1'b0;
            uns_q         <= 1'b0;
            size_q        <= 2'b00;
            lane_q        <= 2'b00;
            wdata_q       <= 16'h0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            misaligned_q  <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            read_data_q   <= 32'h0;
            mem_address_q <= 32'h0;
            mem_wdata_q   <= 32'h0;
        end else begin
            req_ready_q  <= (next_state == IDLE);
            rsp_valid_q  <= (next_state == RESP);
            mem_read_q   <= (next_state == RD) || (next_state == CAP);
            mem_write_q  <= (next_state == WR);
            // the only way from IDLE straight to RESP is a rejected request
            misaligned_q <= accept && illegal_in;

            if (accept) begin
                write_q       <= bus.ReqWrite;
                uns_q         <= bus.ReqUnsigned;
                size_q        <= bus.ReqSize;
                lane_q        <= bus.Address[1:0];
                wdata_q       <= bus.WriteData[15:0];
                mem_address_q <= {bus.Address[31:2], 2'b00};
                rd_cnt        <= '0;
                if (word_store_in && !illegal_in) begin
                    mem_wdata_q <= bus.WriteData;
                end
            end

            if (state == RD) begin
                rd_cnt <= rd_cnt + CW'(1);
            end

            if (state == CAP) begin
                if (write_q) begin
                    mem_wdata_q <= merge_val;
                end else begin
                    read_data_q <= load_val;
                end
            end
        end
    end

    assign bus.ReqReady     = req_ready_q;
    assign bus.RspValid     = rsp_valid_q;
    assign bus.Misaligned   = misaligned_q;
    assign bus.ReadData     = read_data_q;
    assign bus.MemRead      = mem_read_q;
    assign bus.MemWrite     = mem_write_q;
    assign bus.MemAddress   = mem_address_q;
    assign bus.MemWriteData = mem_wdata_q;
    assign dbg_state        = state;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Self-checking bench for load_store_unit: directed scenarios plus random
//   accesses, checked against a byte-array reference memory and latency rules.
module tb_load_store_unit;

    localparam int RD_LAT = 1;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [2:0] dbg_state;

    load_store_unit_if bus ();

    load_store_unit #(.RD_LAT(RD_LAT)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------ clock / reset block
    always #5 Clk = ~Clk;

    // ------------------------------------------------ data memory model
    logic [31:0] tb_mem  [0:15];
    logic [31:0] rd_pipe [0:RD_LAT-1];
    logic        mem_init;

    always @(posedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= 32'h0;
        end else if (bus.MemWrite) begin
            tb_mem[bus.MemAddress[5:2]] <= bus.MemWriteData;
        end
        rd_pipe[0] <= tb_mem[bus.MemAddress[5:2]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign bus.MemReadData = rd_pipe[RD_LAT-1];

    // ------------------------------------------------ reference model
    logic [7:0]  ref_bytes [0:63];
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    endfunction

    function automatic logic [31:0] ref_word(input int word_idx);
        return {ref_bytes[4*word_idx+3], ref_bytes[4*word_idx+2],
                ref_bytes[4*word_idx+1], ref_bytes[4*word_idx]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] sz,
                                             input logic uns);
        int          n;
        int          base;
        logic [31:0] val;
        n    = size_bytes(sz);
        base = int'(addr[5:0]);
        val  = 32'h0;
        for (int i = 0; i < n; i++) val = val | (32'(ref_bytes[base+i]) << (8*i));
        if (!uns && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
        return val;
    endfunction

    // ------------------------------------------------ driver: one request
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        logic        illegal;
        int          n, base, w;
        int          exp_rsp, exp_rd, exp_wr_cyc;
        logic        exp_wr;
        logic [31:0] exp_wdata;
        int          rd_n, wr_n, both_n, rsp_at, wr_at, rd_first;
        logic [31:0] wr_data, wr_addr, rd_addr, rdata;
        logic        mis;

        n       = size_bytes(sz);
        base    = int'(addr[5:0]);
        illegal = (sz == 2'b11) || ((addr % n) != 0);
        exp_wr  = 1'b0;
        exp_wr_cyc = 0;
        exp_wdata  = 32'h0;
        if (illegal) begin
            exp_rsp = 1;
            exp_rd  = 0;
        end else if (wr) begin
            for (int i = 0; i < n; i++) ref_bytes[base+i] = wd[8*i +: 8];
            exp_wdata = ref_word(base / 4);
            exp_wr    = 1'b1;
            if (n == 4) begin
                exp_rd     = 0;
                exp_wr_cyc = 1;
                exp_rsp    = 2;
            end else begin
                exp_rd     = RD_LAT + 1;
                exp_wr_cyc = RD_LAT + 2;
                exp_rsp    = RD_LAT + 3;
            end
        end else begin
            last_rd = ref_load(addr, sz, uns);
            exp_rd  = RD_LAT + 1;
            exp_rsp = RD_LAT + 2;
        end
        exp_q.push_back(last_rd);

        @(negedge Clk);
        bus.ReqWrite    = wr;
        bus.ReqSize     = sz;
        bus.ReqUnsigned = uns;
        bus.Address     = addr;
        bus.WriteData   = wd;
        bus.ReqValid    = 1'b1;
        w = 0;
        while (bus.ReqReady !== 1'b1 && w < 20) begin
            @(negedge Clk);
            w++;
        end
        check_eq("accept_ready", 32'(bus.ReqReady), 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        bus.ReqValid = 1'b0;

        rd_n = 0; wr_n = 0; both_n = 0; rsp_at = 0; wr_at = 0; rd_first = 0;
        wr_data = 32'h0; wr_addr = 32'h0; rd_addr = 32'h0; rdata = 32'h0; mis = 1'b0;
        for (int k = 1; k <= 20 && rsp_at == 0; k++) begin
            if (bus.MemRead) begin
                rd_n++;
                if (rd_first == 0) begin
                    rd_first = k;
                    rd_addr  = bus.MemAddress;
                end
            end
            if (bus.MemWrite) begin
                wr_n++;
                wr_at   = k;
                wr_data = bus.MemWriteData;
                wr_addr = bus.MemAddress;
            end
            if (bus.MemRead && bus.MemWrite) both_n++;
            if (bus.RspValid) begin
                rsp_at = k;
                mis    = bus.Misaligned;
                rdata  = bus.ReadData;
            end else begin
                @(negedge Clk);
            end
        end

        check_eq("rsp_cycle", 32'(rsp_at), 32'(exp_rsp));
        check_eq("misaligned", 32'(mis), 32'(illegal));
        check_eq("read_data", rdata, exp_q.pop_front());
        check_eq("memread_cycles", 32'(rd_n), 32'(exp_rd));
        check_eq("memwrite_cycles", 32'(wr_n), 32'(exp_wr));
        check_eq("rd_wr_overlap", 32'(both_n), 32'd0);
        if (exp_wr) begin
            check_eq("write_cycle", 32'(wr_at), 32'(exp_wr_cyc));
            check_eq("write_data", wr_data, exp_wdata);
            check_eq("write_addr", wr_addr, {addr[31:2], 2'b00});
        end
        if (exp_rd > 0) begin
            check_eq("read_first", 32'(rd_first), 32'd1);
            check_eq("read_addr", rd_addr, {addr[31:2], 2'b00});
        end
        @(negedge Clk);
        check_eq("rsp_pulse", 32'(bus.RspValid), 32'd0);
        check_eq("ready_after", 32'(bus.ReqReady), 32'd1);
    endtask

    // ------------------------------------------------ reset during RD of sb
    task automatic reset_mid_store();
        int wr_n, rsp_n;
        @(negedge Clk);
        bus.ReqWrite    = 1'b1;
        bus.ReqSize     = 2'b10;
        bus.ReqUnsigned = 1'b0;
        bus.Address     = 32'd5;
        bus.WriteData   = 32'h0000_00CD;
        bus.ReqValid    = 1'b1;
        check_eq("rst_pre_ready", 32'(bus.ReqReady), 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        bus.ReqValid = 1'b0;
        check_eq("rst_in_rd", 32'(bus.MemRead), 32'd1);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        check_eq("rst_ready", 32'(bus.ReqReady), 32'd1);
        check_eq("rst_rsp", 32'(bus.RspValid), 32'd0);
        check_eq("rst_memread", 32'(bus.MemRead), 32'd0);
        check_eq("rst_memwrite", 32'(bus.MemWrite), 32'd0);
        check_eq("rst_readdata", bus.ReadData, 32'h0);
        check_eq("rst_memaddr", bus.MemAddress, 32'h0);
        check_eq("rst_memwdata", bus.MemWriteData, 32'h0);
        last_rd = 32'h0;
        wr_n = 0;
        rsp_n = 0;
        repeat (8) begin
            @(negedge Clk);
            if (bus.MemWrite) wr_n++;
            if (bus.RspValid) rsp_n++;
        end
        check_eq("rst_no_write", 32'(wr_n), 32'd0);
        check_eq("rst_no_rsp", 32'(rsp_n), 32'd0);
    endtask

    // ------------------------------------------------ back-to-back loads
    task automatic b2b_loads();
        logic [31:0] addrs [3];
        logic [1:0]  szs   [3];
        logic        unss  [3];
        int          acc_cyc [3];
        int          accepted, rsp_n, c;
        logic        took;
        addrs = '{32'd0, 32'd4, 32'd3};
        szs   = '{2'b00, 2'b01, 2'b10};
        unss  = '{1'b0, 1'b1, 1'b0};
        acc_cyc = '{0, 0, 0};
        for (int i = 0; i < 3; i++) begin
            last_rd = ref_load(addrs[i], szs[i], unss[i]);
            exp_q.push_back(last_rd);
        end
        @(negedge Clk);
        bus.ReqWrite    = 1'b0;
        bus.Address     = addrs[0];
        bus.ReqSize     = szs[0];
        bus.ReqUnsigned = unss[0];
        bus.ReqValid    = 1'b1;
        accepted = 0;
        rsp_n    = 0;
        c        = 0;
        while (rsp_n < 3 && c < 60) begin
            took = 1'b0;
            if (bus.RspValid) begin
                rsp_n++;
                if (exp_q.size() != 0) check_eq("b2b_data", bus.ReadData, exp_q.pop_front());
            end
            if (bus.ReqValid && bus.ReqReady && accepted < 3) begin
                acc_cyc[accepted] = c;
                accepted++;
                took = 1'b1;
            end
            @(posedge Clk);
            @(negedge Clk);
            c++;
            if (took) begin
                if (accepted < 3) begin
                    bus.Address     = addrs[accepted];
                    bus.ReqSize     = szs[accepted];
                    bus.ReqUnsigned = unss[accepted];
                end else begin
                    bus.ReqValid = 1'b0;
                end
            end
        end
        bus.ReqValid = 1'b0;
        check_eq("b2b_rsp_count", 32'(rsp_n), 32'd3);
        check_eq("b2b_accepts", 32'(accepted), 32'd3);
        check_eq("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(RD_LAT + 3));
        check_eq("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(RD_LAT + 3));
        exp_q.delete();
    endtask

    // ------------------------------------------------ main sequence
    initial begin
        Reset           = 1'b1;
        mem_init        = 1'b1;
        bus.ReqValid    = 1'b0;
        bus.ReqWrite    = 1'b0;
        bus.ReqSize     = 2'b00;
        bus.ReqUnsigned = 1'b0;
        bus.Address     = 32'h0;
        bus.WriteData   = 32'h0;
        last_rd         = 32'h0;
        for (int i = 0; i < 64; i++) ref_bytes[i] = 8'h00;

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_eq("reset_ready", 32'(bus.ReqReady), 32'd1);
        check_eq("reset_rsp", 32'(bus.RspValid), 32'd0);
        check_eq("reset_mis", 32'(bus.Misaligned), 32'd0);
        check_eq("reset_memread", 32'(bus.MemRead), 32'd0);
        check_eq("reset_memwrite", 32'(bus.MemWrite), 32'd0);
        check_eq("reset_readdata", bus.ReadData, 32'h0);
        check_eq("reset_memaddr", bus.MemAddress, 32'h0);
        check_eq("reset_memwdata", bus.MemWriteData, 32'h0);
        Reset    = 1'b0;
        mem_init = 1'b0;

        // word store, then byte/half/word loads of a known word
        do_req(1'b1, 2'b00, 1'b0, 32'd0, 32'hFFFF_FFFF);
        do_req(1'b1, 2'b00, 1'b0, 32'd0, 32'h80FF_7F01);
        for (int a = 0; a < 4; a++) do_req(1'b0, 2'b10, 1'b0, 32'(a), 32'h0);
        do_req(1'b0, 2'b10, 1'b1, 32'd3, 32'h0);
        do_req(1'b0, 2'b01, 1'b0, 32'd2, 32'h0);
        do_req(1'b0, 2'b01, 1'b1, 32'd2, 32'h0);
        do_req(1'b0, 2'b01, 1'b0, 32'd0, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 32'd0, 32'h0);

        // read-modify-write stores
        do_req(1'b1, 2'b00, 1'b0, 32'd4, 32'h1122_3344);
        do_req(1'b1, 2'b10, 1'b0, 32'd5, 32'h0000_00AB);
        do_req(1'b1, 2'b01, 1'b0, 32'd6, 32'h0000_BEEF);
        do_req(1'b0, 2'b00, 1'b0, 32'd4, 32'h0);

        // rejected accesses leave ReadData alone
        do_req(1'b0, 2'b01, 1'b0, 32'd1, 32'h0);
        do_req(1'b1, 2'b00, 1'b0, 32'd2, 32'h5555_5555);
        do_req(1'b0, 2'b11, 1'b0, 32'd0, 32'h0);

        reset_mid_store();
        b2b_loads();

        // random traffic
        for (int t = 0; t < 60; t++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
        end

        @(negedge Clk);
        for (int w = 0; w < 16; w++) check_eq("mem_word", tb_mem[w], ref_word(w));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side load/store controller sitting between the MEM pipeline stage and a word-only synchronous data memory. It accepts one byte, halfword or word access request at a time and drives the memory's `MemRead`/`MemWrite` port. Sub-word stores are performed as read-modify-write cycles, and sub-word loads are lane-extracted and sign- or zero-extended. The design is little-endian: the byte at `Address[1:0]=k` is memory word bits `[8k+7:8k]`.

## Interface
- `RD_LAT`, default 1: memory read latency in cycles, ≥1. Read data is valid `RD_LAT` cycles after the first cycle in which `MemRead` and the address are presented.
- `Clk` input, 1: the single clock; rising edge.
- `Reset` input, 1: synchronous, active-high reset.
- `ReqValid` input, 1: request present.
- `ReqReady` output, 1: unit can accept a request; high only in IDLE.
- `ReqWrite` input, 1: 1 = store, 0 = load.
- `ReqSize` input, 2: 00 = word, 01 = half, 10 = byte, 11 = illegal.
- `ReqUnsigned` input, 1: zero-extend sub-word loads (lbu/lhu); ignored for words and stores.
- `Address` input, 32: byte address.
- `WriteData` input, 32: store data, right-aligned.
- `RspValid` output, 1: one-cycle completion pulse.
- `ReadData` output, 32: load result; holds its value until the next load response.
- `Misaligned` output, 1: valid with `RspValid`; the access was rejected.
- `MemAddress` output, 32: `{Address[31:2],2'b00}` of the latched request.
- `MemWriteData` output, 32: merged word to write.
- `MemRead` output, 1: memory read strobe.
- `MemWrite` output, 1: memory write strobe.
- `MemReadData` input, 32: memory read data.

## Operation
- States: IDLE, RD, CAP, WR, RESP.
- **IDLE:** `ReqReady`=1. A request is accepted when `ReqValid`&`ReqReady` is high at the clock edge. The unit latches `Address`, `WriteData`, `ReqWrite`, `ReqSize` and `ReqUnsigned`. Requests arriving in any other state are ignored; the requester holds `ReqValid` until the request is accepted.
- **Alignment check at acceptance:**
  - The access is illegal when any of these holds: `ReqSize`=11, half with `Address[0]`=1, or word with `Address[1:0]`≠0.
  - An illegal access goes to RESP with `Misaligned`=1.
  - It performs no memory access and leaves `ReadData` unchanged.
- **Word store:** IDLE→WR.
- **Loads and sub-word stores:** IDLE→RD.
- **RD:** `MemRead`=1 with `MemAddress` stable for `RD_LAT` cycles, then →CAP.
- **CAP:** `MemRead` stays 1 and `MemReadData` is sampled.
  - Load: the result is extracted into `ReadData` and the unit goes →RESP.
  - Sub-word store: the merged word is registered into `MemWriteData` and the unit goes →WR.
- **Load extraction:**
  - Byte: lane `Address[1:0]`.
  - Half: bits `[31:16]` if `Address[1]`=1, else `[15:0]`.
  - Sign-extend, or zero-extend when `ReqUnsigned`=1.
  - Word: passed through unchanged.
- **Store merge:**
  - Byte: replace lane `Address[1:0]` with `WriteData[7:0]`.
  - Half: replace the half selected by `Address[1]` with `WriteData[15:0]`.
  - Other lanes are kept from `MemReadData`.
- **WR:** `MemWrite`=1 for exactly one cycle, then →RESP. `MemRead` and `MemWrite` are never high in the same cycle.
- **RESP:** `RspValid`=1 for one cycle, then →IDLE. There is no response back-pressure.
- **Reset, at any state:**
  - At the next edge: state = IDLE, `ReqReady`=1.
  - All other outputs are 0, including `ReadData`, `MemAddress` and `MemWriteData`.
  - An in-flight request is discarded: no `MemWrite`, no `RspValid`.

## Timing
Request accepted at edge ending cycle T:
- Misaligned: `RspValid` in T+1.
- Word store: `MemWrite` in T+1, `RspValid` in T+2.
- Load: `MemRead` in T+1..T+1+`RD_LAT`, `RspValid` in T+2+`RD_LAT` (T+3 for `RD_LAT`=1).
- Sub-word store: `MemRead` as for a load, `MemWrite` in T+2+`RD_LAT`, `RspValid` in T+3+`RD_LAT`.
- All outputs are registered. The next request can be accepted at the edge ending the first IDLE cycle after RESP.

## Test plan
1. sw 0xFFFFFFFF @0 → a single `MemWrite` cycle at T+1 with `MemAddress`=0, `MemWriteData`=0xFFFFFFFF, no `MemRead`, `RspValid` at T+2.
2. Memory word 0 = 0x80FF7F01.
   - lb @0/1/2/3 → 0x00000001 / 0x0000007F / 0xFFFFFFFF / 0xFFFFFF80.
   - lbu @3 → 0x00000080.
   - Each load has `RspValid` at T+3.
3. Same word: lh @2 → 0xFFFF80FF; lhu @2 → 0x000080FF; lh @0 → 0x00007F01; lw @0 → 0x80FF7F01.
4. Word 4 = 0x11223344.
   - sb 0xAB @5 → `MemRead` then `MemWrite` with `MemWriteData`=0x1122AB44, `RspValid` at T+4.
   - Then sh 0xBEEF @6 → 0xBEEFAB44.
5. lh @1, sw @2, `ReqSize`=11 @0 → each gives `RspValid`=`Misaligned`=1 at T+1, no `MemRead`/`MemWrite`, and `ReadData` unchanged.
6. Reset asserted during RD of sb @5 → no `MemWrite` and no `RspValid`; `ReqReady`=1 after the reset edge. Then `ReqValid` held high for 3 back-to-back loads → exactly 3 responses, each accepted only in IDLE.
